// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into DATA_WIDTH-bit words with strobes.
// Define AXIS_BYTE_PACKER_BIG_ENDIAN_EN to fill lanes from the MSB down.
module axis_byte_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = $clog2(LANES)
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    input  logic [7:0]            s01_axis_tdata,
    input  logic                  s01_axis_tstrb,
    input  logic                  s01_axis_tvalid,
    input  logic                  s01_axis_tlast,
    output logic                  s01_axis_tready,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic [LANES-1:0]      m01_axis_tstrb,
    output logic                  m01_axis_tvalid,
    output logic                  m01_axis_tlast,
    input  logic                  m01_axis_tready,
    output logic [15:0]           pkt_count
);

    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  lane;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_with;
    logic [LANES-1:0]      strb;
    logic [LANES-1:0]      strb_with;
    logic                  beat;
    logic                  complete;
    logic                  out_fire;

    assign s01_axis_tready = !axis_areset && (!m01_axis_tvalid || m01_axis_tready);
    assign beat     = s01_axis_tvalid && s01_axis_tready;
    assign out_fire = m01_axis_tvalid && m01_axis_tready;
    assign complete = beat && ((s01_axis_tstrb && cnt == CNT_WIDTH'(LANES - 1))
                               || s01_axis_tlast);

    // Accumulator as it would look with the current byte merged in.
    always_comb begin
`ifdef AXIS_BYTE_PACKER_BIG_ENDIAN_EN
        lane = CNT_WIDTH'(LANES - 1) - cnt;
`else
        lane = cnt;
`endif
        acc_with  = acc;
        strb_with = strb;
        if (s01_axis_tstrb) begin
            acc_with        = acc | (DATA_WIDTH'(s01_axis_tdata) << (8 * lane));
            strb_with[lane] = 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            cnt             <= '0;
            acc             <= '0;
            strb            <= '0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
        end else if (complete) begin
            m01_axis_tdata  <= acc_with;
            m01_axis_tstrb  <= strb_with;
            m01_axis_tlast  <= s01_axis_tlast;
            m01_axis_tvalid <= 1'b1;
            cnt             <= '0;
            acc             <= '0;
            strb            <= '0;
        end else begin
            if (out_fire) begin
                m01_axis_tvalid <= 1'b0;
            end
            if (beat && s01_axis_tstrb) begin
                acc  <= acc_with;
                strb <= strb_with;
                cnt  <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            pkt_count <= '0;
        end else if (out_fire && m01_axis_tlast) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer: byte-list reference model,
// randomized traffic and backpressure, plus the directed packet cases.
module tb_axis_byte_packer;

    localparam int DW = 32;
    localparam int LN = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_data;
    logic          s_strb;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic [LN-1:0] m_strb;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic [15:0]   pkt_count;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [LN-1:0] s;
        logic          l;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] pend[$];
    int         tests = 0;
    int         fails = 0;
    int         exp_pkt = 0;
    int         rmode = 0;

    axis_byte_packer #(.DATA_WIDTH(DW)) dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .s01_axis_tdata  (s_data),
        .s01_axis_tstrb  (s_strb),
        .s01_axis_tvalid (s_valid),
        .s01_axis_tlast  (s_last),
        .s01_axis_tready (s_ready),
        .m01_axis_tdata  (m_data),
        .m01_axis_tstrb  (m_strb),
        .m01_axis_tvalid (m_valid),
        .m01_axis_tlast  (m_last),
        .m01_axis_tready (m_ready),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference: collect valid bytes; a full word or tlast emits one word.
    function automatic void model(input logic [7:0] d, input logic s,
                                  input logic l);
        word_t w;
        int    ln;
        if (s) pend.push_back(d);
        if (pend.size() == LN || l) begin
            w = '0;
            for (int i = 0; i < pend.size(); i++) begin
`ifdef AXIS_BYTE_PACKER_BIG_ENDIAN_EN
                ln = LN - 1 - i;
`else
                ln = i;
`endif
                w.d[8*ln +: 8] = pend[i];
                w.s[ln] = 1'b1;
            end
            w.l = l;
            exp_q.push_back(w);
            pend.delete();
        end
    endfunction

    task automatic send(input logic [7:0] d, input logic s, input logic l);
        int n = 0;
        model(d, s, l);
        s_data = d;
        s_strb = s;
        s_last = l;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0",
                     exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    word_t held;
    word_t got;
    logic  had_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            had_hold = 1'b0;
        end else begin
            if (had_hold && m_valid) begin
                chk("hold_data", m_data, held.d);
                chk("hold_strb", 32'(m_strb), 32'(held.s));
                chk("hold_last", 32'(m_last), 32'(held.l));
            end
            had_hold = m_valid && !m_ready;
            held = {m_data, m_strb, m_last};
            if (m_valid && !m_ready) chk("s_tready_blocked", 32'(s_ready), 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none", m_data);
                end else begin
                    got = exp_q.pop_front();
                    chk("word_data", m_data, got.d);
                    chk("word_strb", 32'(m_strb), 32'(got.s));
                    chk("word_last", 32'(m_last), 32'(got.l));
                end
                chk("pkt_count", 32'(pkt_count), exp_pkt);
                if (m_last) exp_pkt = (exp_pkt + 1) & 16'hFFFF;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        pend.delete();
        exp_q.delete();
        exp_pkt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        s_data = '0;
        s_strb = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", 32'(m_valid), 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_strb", 32'(m_strb), 0);
        chk("reset_m_last", 32'(m_last), 0);
        chk("reset_s_ready", 32'(s_ready), 0);
        chk("reset_pkt_count", 32'(pkt_count), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(8'h11, 1, 0); send(8'h22, 1, 0);
        send(8'h33, 1, 0); send(8'h44, 1, 1);
        send(8'h55, 1, 0); send(8'h22, 1, 1);
        send(8'hAA, 1, 0); send(8'hFF, 0, 0); send(8'hBB, 1, 0);
        send(8'hCC, 1, 0); send(8'hDD, 1, 1);
        wait_drain();
        chk("pkt_count_directed", 32'(pkt_count), 3);

        rmode = 2;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(8'(i), 1, 1'(i == 8));
            end
            begin
                repeat (10) @(posedge clk);
                rmode = 0;
            end
        join
        send(8'h77, 0, 1);
        wait_drain();
        chk("pkt_count_null_last", 32'(pkt_count), 5);

        rmode = 2;
        send(8'h11, 1, 0); send(8'h22, 1, 0);
        send(8'h33, 1, 0); send(8'h44, 1, 0);
        do_reset();
        rmode = 0;
        send(8'h11, 1, 0); send(8'h22, 1, 0);
        do_reset();
        send(8'h33, 1, 0); send(8'h44, 1, 0);
        send(8'h55, 1, 0); send(8'h66, 1, 1);
        wait_drain();
        chk("pkt_count_after_reset", 32'(pkt_count), 1);

        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) rmode = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 5) == 0));
        end
        send(8'hEE, 1, 1);
        rmode = 0;
        wait_drain();
        chk("pkt_count_final", 32'(pkt_count), exp_pkt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
